// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Program-counter and fetch-redirect controller for the 4-stage core. Holds
// the fetch PC, advances it every cycle, and when the branch unit asks for a
// redirect it loads the target and squashes the younger in-flight slots for
// a fixed number of cycles. It also qualifies fetch and counts redirects.
//
// Parameters:
//   PC_W          width of pc / new_pc (word-addressed)
//   RESET_PC      pc value loaded on reset
//   FLUSH_CYCLES  cycles flush stays high per redirect, including the
//                 redirect cycle itself (1..15)
//
// Ports:
//   clk           core clock, rising edge
//   rst           asynchronous active-high reset
//   stall         hold request from downstream hazard logic
//   load_new_pc   taken branch / jump from the branch condition unit
//   new_pc        redirect target, meaningful only with load_new_pc
//   pc            current fetch address (registered)
//   fetch_valid   instruction at pc may enter decode this cycle
//   flush         kill all younger pipeline slots this cycle
//   redirect_cnt  number of accepted redirects, saturating at all-ones
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
   parameter int              PC_W         = 16,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            load_new_pc,
   input  logic [PC_W-1:0] new_pc,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            flush,
   output logic [15:0]     redirect_cnt
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // The redirect cycle is the first flush cycle, so the counter only has
   // to cover the remaining ones.
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      flush_cnt_q, flush_cnt_d;
   logic [15:0]     redirect_cnt_q, redirect_cnt_d;

   // State, PC, flush counter and redirect counter registers. Reset puts the
   // controller back in BOOT, which decodes to no flush and no valid fetch,
   // so a reset in the middle of a flush leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         flush_cnt_q    <= 4'd0;
         redirect_cnt_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         flush_cnt_q    <= flush_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   // Next-state and output decode. In RUN a redirect beats a stall, which
   // beats the normal increment. new_pc is only steered into the PC when a
   // redirect is actually accepted, so garbage on it at other times cannot
   // leak into the PC. Redirect requests seen during FLUSH come from slots
   // that are being squashed and are dropped.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      flush_cnt_d    = flush_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      fetch_valid    = 1'b0;
      flush          = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (load_new_pc) begin
               flush = 1'b1;
               pc_d  = new_pc;
               if (redirect_cnt_q != 16'hFFFF) begin
                  redirect_cnt_d = redirect_cnt_q + 16'd1;
               end
               if (FLUSH_CYCLES > 1) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end
            end else begin
               fetch_valid = 1'b1;
               if (!stall) begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         FLUSH: begin
            flush       = 1'b1;
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q == 4'd1) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   assign pc           = pc_q;
   assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Drives three copies of the controller (FLUSH_CYCLES = 2, 4 and 1) from the
// same stimulus and compares every output of every copy, every cycle, with a
// behavioural model. The model only tracks "where fetch is", "how many more
// cycles are squashed" and "how many redirects were taken", plus a boot flag.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        load_new_pc = 1'b0;
   logic [15:0] new_pc = 16'd0;

   logic [15:0] pc_o  [3];
   logic        fv_o  [3];
   logic        fl_o  [3];
   logic [15:0] cnt_o [3];

   int m_pc   [3];
   int m_left [3];
   int m_cnt  [3];
   bit m_boot [3];

   int check_count = 0;
   int pass_count  = 0;
   bit started     = 1'b0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2)) dut_fc2 (
      .clk(clk), .rst(rst), .stall(stall), .load_new_pc(load_new_pc), .new_pc(new_pc),
      .pc(pc_o[0]), .fetch_valid(fv_o[0]), .flush(fl_o[0]), .redirect_cnt(cnt_o[0])
   );

   pc_redirect_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(4)) dut_fc4 (
      .clk(clk), .rst(rst), .stall(stall), .load_new_pc(load_new_pc), .new_pc(new_pc),
      .pc(pc_o[1]), .fetch_valid(fv_o[1]), .flush(fl_o[1]), .redirect_cnt(cnt_o[1])
   );

   pc_redirect_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(1)) dut_fc1 (
      .clk(clk), .rst(rst), .stall(stall), .load_new_pc(load_new_pc), .new_pc(new_pc),
      .pc(pc_o[2]), .fetch_valid(fv_o[2]), .flush(fl_o[2]), .redirect_cnt(cnt_o[2])
   );

   function automatic int fcOf(input int i);
      case (i)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         m_pc[i]   = 0;
         m_left[i] = 0;
         m_cnt[i]  = 0;
         m_boot[i] = 1'b1;
      end
   endtask

   // What each copy should do on a rising edge, given the inputs that were
   // held across it.
   task automatic modelEdge();
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_boot[i] = 1'b1;
         end else if (m_boot[i]) begin
            m_boot[i] = 1'b0;
         end else if (m_left[i] > 0) begin
            m_left[i] = m_left[i] - 1;
         end else if (load_new_pc) begin
            m_pc[i]   = int'(new_pc);
            m_cnt[i]  = (m_cnt[i] < 65535) ? m_cnt[i] + 1 : 65535;
            m_left[i] = fcOf(i) - 1;
         end else if (!stall) begin
            m_pc[i] = (m_pc[i] + 1) % 65536;
         end
      end
   endtask

   // One cycle: let the previous inputs take effect at the rising edge,
   // drive new inputs at the falling edge, then compare all outputs.
   task automatic applyStimulus(input logic r, input logic s, input logic l,
                                input logic [15:0] np);
      bit exp_fv;
      bit exp_fl;
      if (started) begin
         @(posedge clk);
         modelEdge();
      end
      started = 1'b1;
      @(negedge clk);
      rst         = r;
      stall       = s;
      load_new_pc = l;
      new_pc      = np;
      if (r) modelReset();
      #1;
      for (int i = 0; i < 3; i++) begin
         if (r || m_boot[i]) begin
            exp_fv = 1'b0; exp_fl = 1'b0;
         end else if (m_left[i] > 0 || l) begin
            exp_fv = 1'b0; exp_fl = 1'b1;
         end else begin
            exp_fv = 1'b1; exp_fl = 1'b0;
         end
         checkOutput($sformatf("fc%0d pc", fcOf(i)), 32'(pc_o[i]), 32'(m_pc[i]));
         checkOutput($sformatf("fc%0d fetch_valid", fcOf(i)), 32'(fv_o[i]), 32'(exp_fv));
         checkOutput($sformatf("fc%0d flush", fcOf(i)), 32'(fl_o[i]), 32'(exp_fl));
         checkOutput($sformatf("fc%0d redirect_cnt", fcOf(i)), 32'(cnt_o[i]), 32'(m_cnt[i]));
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      // Reset for three cycles, then the boot cycle, then free-running fetch.
      modelReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("reset pc", 32'(pc_o[0]), 32'h0000);
      checkOutput("reset flush", 32'(fl_o[0]), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      idle();
      checkOutput("boot fetch_valid", 32'(fv_o[0]), 32'h0);
      for (int k = 0; k < 4; k++) begin
         idle();
         checkOutput("free-run pc", 32'(pc_o[0]), 32'(k));
         checkOutput("free-run fetch_valid", 32'(fv_o[0]), 32'h1);
      end

      // Taken branch at pc=5 to 0x40.
      idle();
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
      checkOutput("branch source pc", 32'(pc_o[0]), 32'h0005);
      checkOutput("branch flush cycle 1", 32'(fl_o[0]), 32'h1);
      idle();
      checkOutput("branch flush cycle 2", 32'(fl_o[0]), 32'h1);
      checkOutput("branch flush fetch_valid", 32'(fv_o[0]), 32'h0);
      idle();
      checkOutput("branch target pc", 32'(pc_o[0]), 32'h0040);
      checkOutput("branch target valid", 32'(fv_o[0]), 32'h1);
      checkOutput("branch redirect_cnt", 32'(cnt_o[0]), 32'h1);
      idle();
      checkOutput("branch target+1", 32'(pc_o[0]), 32'h0041);

      // Stall holds the PC; a redirect wins over a concurrent stall.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0009);
      idle();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
         checkOutput("stall pc hold", 32'(pc_o[0]), 32'h0009);
         checkOutput("stall fetch_valid", 32'(fv_o[0]), 32'h1);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100);
      checkOutput("redirect beats stall flush", 32'(fl_o[0]), 32'h1);
      idle();
      idle();
      checkOutput("redirect beats stall pc", 32'(pc_o[0]), 32'h0100);

      // A second redirect request during FLUSH is dropped.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0180);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0200);
      idle();
      checkOutput("ignored redirect pc", 32'(pc_o[0]), 32'h0180);
      checkOutput("ignored redirect cnt", 32'(cnt_o[0]), 32'h4);

      // PC wraps from all-ones to zero.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
      idle();
      idle();
      checkOutput("wrap pc FFFE", 32'(pc_o[0]), 32'hFFFE);
      idle();
      checkOutput("wrap pc FFFF", 32'(pc_o[0]), 32'hFFFF);
      idle();
      checkOutput("wrap pc 0000", 32'(pc_o[0]), 32'h0000);

      // Reset during the second flush cycle of the FLUSH_CYCLES=4 copy.
      for (int k = 0; k < 4; k++) idle();
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0050);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("mid-flush reset flush", 32'(fl_o[1]), 32'h0);
      checkOutput("mid-flush reset fetch_valid", 32'(fv_o[1]), 32'h0);
      checkOutput("mid-flush reset pc", 32'(pc_o[1]), 32'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      idle();
      checkOutput("post-reset boot flush", 32'(fl_o[1]), 32'h0);
      idle();
      checkOutput("post-reset run pc", 32'(pc_o[1]), 32'h0000);

      // Random traffic with occasional asynchronous resets.
      for (int k = 0; k < 3000; k++) begin
         applyStimulus($urandom_range(63) == 0, $urandom_range(3) == 0,
                       $urandom_range(5) == 0, 16'($urandom));
      end

      // Back-to-back redirects until the FLUSH_CYCLES=1 counter saturates.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 65540; k++) begin
         applyStimulus(1'b0, 1'($urandom_range(1)), 1'b1, 16'($urandom));
      end
      checkOutput("saturated redirect_cnt", 32'(cnt_o[2]), 32'hFFFF);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Program-counter and fetch-redirect controller for the 4-stage core; it is the consumer of the branch unit's load_new_pc decision. It holds the fetch PC, advances it each cycle, and on a taken branch or jump loads the target and squashes younger in-flight slots. It also emits a fetch-valid qualifier and keeps a redirect performance counter.

Parameters:
PC_W, 16, width of PC and branch target (word-addressed).
RESET_PC, 16'h0000, PC value loaded on reset.
FLUSH_CYCLES, 2, total cycles flush stays high per redirect (legal range 1..15).

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hold request from downstream hazard logic.
load_new_pc  input  1  taken-branch/jump indication from branch condition unit.
new_pc  input  PC_W  branch/jump target, valid when load_new_pc=1.
pc  output  PC_W  current fetch address (registered).
fetch_valid  output  1  instruction fetched at pc may enter decode this cycle.
flush  output  1  kill all younger pipeline slots this cycle.
redirect_cnt  output  16  count of accepted redirects, saturating.

Behaviour:
- Reset (async assert, sync deassert by integration): pc=RESET_PC, state=BOOT, flush_cnt=0, redirect_cnt=0. Outputs during reset: fetch_valid=0, flush=0.
- States: BOOT, RUN, FLUSH. 4-bit down counter flush_cnt.
- BOOT: one cycle; fetch_valid=0, flush=0, pc held; unconditionally -> RUN. load_new_pc and stall ignored.
- RUN, priority load_new_pc > stall > advance:
  - load_new_pc=1: flush=1 and fetch_valid=0 combinationally in the same cycle; next edge pc<=new_pc, redirect_cnt+=1 (saturate at 16'hFFFF). If FLUSH_CYCLES=1 stay RUN; else -> FLUSH with flush_cnt<=FLUSH_CYCLES-1.
  - stall=1 (no redirect): pc held, fetch_valid=1, flush=0.
  - otherwise: pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0), fetch_valid=1, flush=0.
- FLUSH: flush=1, fetch_valid=0, pc held at target; flush_cnt decrements each cycle; when flush_cnt=1 on an edge -> RUN. stall does not extend FLUSH. load_new_pc during FLUSH is ignored (source slot is being squashed); redirect_cnt unchanged.
- First fetch_valid cycle after FLUSH presents pc=target exactly once before incrementing (unless stalled).
- Total flush pulse per redirect = FLUSH_CYCLES consecutive cycles, including the load_new_pc cycle.
- new_pc sampled only in RUN with load_new_pc=1; X on new_pc otherwise must not propagate.
- Reset asserted mid-FLUSH or mid-stall: immediate return to reset values, no residual flush.
- pc, redirect_cnt, state, flush_cnt are flops; fetch_valid and flush are combinational decodes of state and load_new_pc/stall only (no input-to-pc combinational path).

Test Plan:
- Reset then free-run: rst high 3 cycles, release -> BOOT cycle with pc=0, fetch_valid=0; then pc 0,1,2,3 with fetch_valid=1, flush=0.
- Taken branch, FLUSH_CYCLES=2: at pc=5 pulse load_new_pc with new_pc=16'h0040 -> flush=1 that cycle and next, fetch_valid=0 both; then pc=0x40 fetch_valid=1, next 0x41; redirect_cnt=1.
- Stall vs redirect: stall=1 for 3 cycles at pc=9 -> pc holds 9, fetch_valid=1; assert load_new_pc with stall=1, new_pc=0x100 -> redirect taken, pc=0x100 after flush.
- Redirect ignored in FLUSH: second load_new_pc (new_pc=0x200) in FLUSH cycle -> pc stays at first target, redirect_cnt increments by 1 only.
- Wrap and saturation: start pc=0xFFFE -> 0xFFFF, 0x0000; preload 65535 redirects (or force) -> redirect_cnt stays 0xFFFF on next redirect.
- Reset mid-flush with FLUSH_CYCLES=4: rst asserted during 2nd flush cycle -> flush=0, fetch_valid=0, pc=RESET_PC immediately, BOOT after release.
